// File: rtl/tsu_queue_arb.sv
// tsu_queue_arb: pops timestamp entries from the RX and TX TSU queues one at a
// time and presents them on a valid/ready output with the source tagged.
// Configuration macro TSU_QUEUE_ARB_RX_PRIO_EN: when defined, RX has strict
// priority; when undefined (default), the two queues are served round-robin.
module tsu_queue_arb #(
  parameter int DATA_W = 128
) (
  input  logic              q_rd_clk,
  input  logic              rst,

  input  logic [7:0]        rx_q_rd_stat,
  output logic              rx_q_rd_en,
  input  logic [DATA_W-1:0] rx_q_rd_data,

  input  logic [7:0]        tx_q_rd_stat,
  output logic              tx_q_rd_en,
  input  logic [DATA_W-1:0] tx_q_rd_data,

  output logic              ts_valid,
  input  logic              ts_ready,
  output logic              ts_src,
  output logic [DATA_W-1:0] ts_data,

  output logic [15:0]       rx_pop_cnt,
  output logic [15:0]       tx_pop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WT   = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // grant doubles as the round-robin "last granted" memory: it only changes
  // on entry to RD, so in IDLE it still names the previous winner (0=RX, 1=TX).
  logic grant;
  logic next_grant;

  logic rx_req;
  logic tx_req;
  logic arb_pick;
  logic next_rx_rd_en;
  logic next_tx_rd_en;
  logic capture;
  logic transfer;

  assign rx_req = (rx_q_rd_stat != 8'd0);
  assign tx_req = (tx_q_rd_stat != 8'd0);

`ifdef TSU_QUEUE_ARB_RX_PRIO_EN
  // RX wins whenever it has anything; TX only when RX is empty.
  assign arb_pick = ~rx_req;
`else
  // On a tie hand the grant to whoever did not win last; otherwise the lone requester.
  assign arb_pick = (rx_req && tx_req) ? ~grant : ~rx_req;
`endif

  // Output entry is valid exactly while parked in HOLD, so reset drops it at once.
  assign ts_valid = (state == HOLD);

  // Next-state, grant and strobe decode; stats are looked at only in IDLE.
  always_comb begin
    next_state    = state;
    next_grant    = grant;
    next_rx_rd_en = 1'b0;
    next_tx_rd_en = 1'b0;
    capture       = 1'b0;
    transfer      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_req || tx_req) begin
          next_state    = RD;
          next_grant    = arb_pick;
          next_rx_rd_en = ~arb_pick;
          next_tx_rd_en = arb_pick;
        end
      end
      RD: begin
        next_state = WT;
      end
      WT: begin
        next_state = HOLD;
        capture    = 1'b1;
      end
      HOLD: begin
        if (ts_ready) begin
          next_state = IDLE;
          transfer   = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and grant registers; reset leaves TX as last winner so RX goes first.
  always_ff @(posedge q_rd_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b1;
    end else begin
      state <= next_state;
      grant <= next_grant;
    end
  end

  // Pop strobes are flopped so each is high for exactly the one RD cycle.
  always_ff @(posedge q_rd_clk or posedge rst) begin
    if (rst) begin
      rx_q_rd_en <= 1'b0;
      tx_q_rd_en <= 1'b0;
    end else begin
      rx_q_rd_en <= next_rx_rd_en;
      tx_q_rd_en <= next_tx_rd_en;
    end
  end

  // Queue data is valid during WT; latch it with its source and hold through HOLD.
  always_ff @(posedge q_rd_clk or posedge rst) begin
    if (rst) begin
      ts_data <= '0;
      ts_src  <= 1'b0;
    end else if (capture) begin
      ts_data <= grant ? tx_q_rd_data : rx_q_rd_data;
      ts_src  <= grant;
    end
  end

  // Delivered-entry counters, bumped on the accepting edge and wrapping naturally.
  always_ff @(posedge q_rd_clk or posedge rst) begin
    if (rst) begin
      rx_pop_cnt <= 16'd0;
      tx_pop_cnt <= 16'd0;
    end else if (transfer) begin
      if (ts_src) begin
        tx_pop_cnt <= tx_pop_cnt + 16'd1;
      end else begin
        rx_pop_cnt <= rx_pop_cnt + 16'd1;
      end
    end
  end

endmodule
